// File: rtl/ucsbece154b_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// ucsbece154b_fetch_unit_if
// Instruction-memory request/response bus between the fetch unit and memory.
//   req    : fetch unit has a request at PCF this cycle
//   gnt    : memory accepts the request this cycle
//   rvalid : in-order response valid (at least one cycle after its grant)
//   rdata  : response instruction word
// Modports: master = fetch unit side, slave = memory side.
// ----------------------------------------------------------------------------
interface ucsbece154b_fetch_unit_if;
    logic        req;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/ucsbece154b_fetch_unit.sv
// ----------------------------------------------------------------------------
// ucsbece154b_fetch_unit
// Fetch stage: PC generator, credit-limited in-order instruction-memory port
// and a DEPTH-entry instruction queue feeding Decode. Redirects from Execute
// flush the queue and discard every response still in flight.
// Ports:
//   clk, reset          : clock (rising edge), asynchronous active-high reset
//   PCSrcE_i/PCTargetE_i: redirect request and target from Execute
//   StallD_i            : Decode not accepting, head entry is held
//   PCF_o               : address of the next request
//   imem                : request/response bus (master side)
//   valid_o             : queue head valid
//   InstrD_o/PCD_o/PCPlus4D_o : head instruction / PC / PC+4 (NOP/0/0 if empty)
// ----------------------------------------------------------------------------
module ucsbece154b_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] PC_START = 32'h0001_0000,
    parameter logic [31:0]     NOP      = 32'h0000_0013
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          PCSrcE_i,
    input  logic [XLEN-1:0]               PCTargetE_i,
    input  logic                          StallD_i,
    output logic [XLEN-1:0]               PCF_o,
    ucsbece154b_fetch_unit_if.master      imem,
    output logic                          valid_o,
    output logic [31:0]                   InstrD_o,
    output logic [XLEN-1:0]               PCD_o,
    output logic [XLEN-1:0]               PCPlus4D_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0] r_pcf;
    logic [XLEN-1:0] r_resp_pc;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_cnt;
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [31:0]     r_instr [DEPTH];
    logic [XLEN-1:0] r_pc    [DEPTH];

    logic [CW:0]     w_inflight;
    logic            w_req;
    logic            w_accept;
    logic            w_drop;
    logic            w_push;
    logic            w_pop;

    // Queued entries plus in-flight requests never exceed DEPTH, so a
    // response always finds a free slot.
    assign w_inflight = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_req      = !PCSrcE_i && (w_inflight < (CW+1)'(DEPTH));
    assign w_accept   = w_req && imem.gnt;

    // A response is stale if it arrives in a redirect cycle or while
    // responses from before an earlier redirect are still being drained.
    assign w_drop     = imem.rvalid && (PCSrcE_i || (r_drop_cnt != '0));
    assign w_push     = imem.rvalid && !w_drop;
    assign w_pop      = valid_o && !StallD_i && !PCSrcE_i;

    assign imem.req   = w_req;
    assign PCF_o      = r_pcf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pcf         <= PC_START;
            r_resp_pc     <= PC_START;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_head        <= '0;
            r_tail        <= '0;
        end else begin
            case ({w_accept, imem.rvalid})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: r_outstanding <= r_outstanding;
            endcase

            if (PCSrcE_i) begin
                // Every response still in flight after this edge belongs to
                // the old stream; outstanding already covers earlier drops.
                r_drop_cnt <= r_outstanding - CW'(imem.rvalid);
                r_pcf      <= PCTargetE_i;
                r_resp_pc  <= PCTargetE_i;
                r_count    <= '0;
                r_head     <= '0;
                r_tail     <= '0;
            end else begin
                if (imem.rvalid && (r_drop_cnt != '0)) begin
                    r_drop_cnt <= r_drop_cnt - CW'(1);
                end
                if (w_accept) begin
                    r_pcf <= r_pcf + XLEN'(4);
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + XLEN'(4);
                    r_tail    <= r_tail + AW'(1);
                end
                if (w_pop) begin
                    r_head <= r_head + AW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Storage needs no reset: outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr[r_tail] <= imem.rdata;
            r_pc[r_tail]    <= r_resp_pc;
        end
    end

    always_comb begin
        valid_o    = (r_count != '0);
        InstrD_o   = NOP;
        PCD_o      = '0;
        PCPlus4D_o = '0;
        if (valid_o) begin
            InstrD_o   = r_instr[r_head];
            PCD_o      = r_pc[r_head];
            PCPlus4D_o = r_pc[r_head] + XLEN'(4);
        end
    end

endmodule

// File: tb/tb_ucsbece154b_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_ucsbece154b_fetch_unit
// Directed bench for the fetch unit with an in-order variable-latency memory
// model. Each popped head entry is compared with the expected PC stream and
// the word the memory holds at that PC.
// ----------------------------------------------------------------------------
module tb_ucsbece154b_fetch_unit;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] PC_START = 32'h0001_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        PCSrcE_i;
    logic [31:0] PCTargetE_i;
    logic        StallD_i;
    logic [31:0] PCF_o;
    logic        valid_o;
    logic [31:0] InstrD_o;
    logic [31:0] PCD_o;
    logic [31:0] PCPlus4D_o;

    ucsbece154b_fetch_unit_if imem ();

    ucsbece154b_fetch_unit #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .PC_START (PC_START),
        .NOP      (NOP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .PCSrcE_i    (PCSrcE_i),
        .PCTargetE_i (PCTargetE_i),
        .StallD_i    (StallD_i),
        .PCF_o       (PCF_o),
        .imem        (imem.master),
        .valid_o     (valid_o),
        .InstrD_o    (InstrD_o),
        .PCD_o       (PCD_o),
        .PCPlus4D_o  (PCPlus4D_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          checks;
    int          errors;
    int          cyc;
    int          lat;
    logic [31:0] exp_pc;
    logic [31:0] q_addr [$];
    int          q_due  [$];
    logic        s_acc;
    logic        s_rv;
    logic [31:0] s_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample handshake, check any pop against the expected
    // stream, then advance the memory model after the edge.
    task automatic tick();
        #1;
        s_acc  = imem.req && imem.gnt;
        s_rv   = imem.rvalid;
        s_addr = PCF_o;
        if (PCSrcE_i) begin
            exp_pc = PCTargetE_i;
        end else if (valid_o && !StallD_i) begin
            chk("pop_pc", PCD_o, exp_pc);
            chk("pop_instr", InstrD_o, mem_word(exp_pc));
            chk("pop_pc4", PCPlus4D_o, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
        end
        chk("credit", 32'(q_addr.size() <= DEPTH), 32'd1);
        @(posedge clk);
        #1;
        cyc++;
        if (s_rv && q_addr.size() > 0) begin
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
        if (s_acc) begin
            q_addr.push_back(s_addr);
            q_due.push_back(cyc + lat - 1);
        end
        if (q_addr.size() > 0 && q_due[0] <= cyc) begin
            imem.rvalid = 1'b1;
            imem.rdata  = mem_word(q_addr[0]);
        end else begin
            imem.rvalid = 1'b0;
            imem.rdata  = '0;
        end
        @(negedge clk);
    endtask

    // Reset also stops the memory model: nothing in flight survives it.
    task automatic do_reset();
        reset       = 1'b1;
        PCSrcE_i    = 1'b0;
        q_addr.delete();
        q_due.delete();
        imem.rvalid = 1'b0;
        imem.rdata  = '0;
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b0;
        exp_pc = PC_START;
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] pc);
        for (int i = 0; i < 20; i++) begin
            if (!valid_o) tick();
        end
        chk({tag, "_valid"}, 32'(valid_o), 32'd1);
        chk({tag, "_pc"}, PCD_o, pc);
        chk({tag, "_instr"}, InstrD_o, mem_word(pc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks      = 0;
        errors      = 0;
        cyc         = 0;
        lat         = 1;
        exp_pc      = PC_START;
        reset       = 1'b1;
        PCSrcE_i    = 1'b0;
        PCTargetE_i = '0;
        StallD_i    = 1'b0;
        imem.gnt    = 1'b0;
        imem.rvalid = 1'b0;
        imem.rdata  = '0;
        @(negedge clk);
        @(negedge clk);

        // Reset values
        #1;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_instr", InstrD_o, NOP);
        chk("rst_pcd", PCD_o, 32'd0);
        chk("rst_pc4", PCPlus4D_o, 32'd0);
        chk("rst_pcf", PCF_o, PC_START);
        @(negedge clk);

        // Streaming, latency 1, no stalls: valid in the third cycle
        reset    = 1'b0;
        imem.gnt = 1'b1;
        exp_pc   = PC_START;
        chk("s1_req", 32'(imem.req), 32'd1);
        chk("s1_v0", 32'(valid_o), 32'd0);
        tick();
        chk("s1_v1", 32'(valid_o), 32'd0);
        tick();
        chk("s1_v2", 32'(valid_o), 32'd1);
        chk("s1_head", PCD_o, PC_START);
        for (int i = 0; i < 8; i++) begin
            chk("s1_stream_valid", 32'(valid_o), 32'd1);
            tick();
        end

        // Decode stalled for 10 cycles: credits run out, head held
        do_reset();
        StallD_i = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        #1;
        chk("s2_req_off", 32'(imem.req), 32'd0);
        chk("s2_valid", 32'(valid_o), 32'd1);
        chk("s2_head", PCD_o, PC_START);
        chk("s2_instr", InstrD_o, mem_word(PC_START));
        chk("s2_inflight", 32'(q_addr.size()), 32'd0);
        StallD_i = 1'b0;
        for (int i = 0; i < 12; i++) tick();

        // Latency 3, three outstanding, redirect to 0x10100
        do_reset();
        lat = 3;
        for (int i = 0; i < 3; i++) tick();
        imem.gnt    = 1'b0;
        PCSrcE_i    = 1'b1;
        PCTargetE_i = 32'h0001_0100;
        #1;
        chk("s3_inflight", 32'(q_addr.size()), 32'd3);
        chk("s3_rvalid", 32'(imem.rvalid), 32'd1);
        chk("s3_req_off", 32'(imem.req), 32'd0);
        tick();
        PCSrcE_i = 1'b0;
        imem.gnt = 1'b1;
        chk("s3_flushed", 32'(valid_o), 32'd0);
        chk("s3_pcf", PCF_o, 32'h0001_0100);
        wait_valid("s3_first", 32'h0001_0100);
        for (int i = 0; i < 8; i++) tick();

        // Redirect with a response and a pop in the same cycle (count 3)
        do_reset();
        lat      = 1;
        StallD_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("s4_rvalid", 32'(imem.rvalid), 32'd1);
        chk("s4_valid", 32'(valid_o), 32'd1);
        StallD_i    = 1'b0;
        PCSrcE_i    = 1'b1;
        PCTargetE_i = 32'h0002_0000;
        tick();
        PCSrcE_i = 1'b0;
        chk("s4_empty", 32'(valid_o), 32'd0);
        wait_valid("s4_first", 32'h0002_0000);

        // Redirect with a pop at a full queue
        StallD_i = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        #1;
        chk("s4b_full_req", 32'(imem.req), 32'd0);
        StallD_i    = 1'b0;
        PCSrcE_i    = 1'b1;
        PCTargetE_i = 32'h0003_0004;
        tick();
        PCSrcE_i = 1'b0;
        chk("s4b_empty", 32'(valid_o), 32'd0);
        wait_valid("s4b_first", 32'h0003_0004);

        // Random grants, latencies, stalls and redirects
        do_reset();
        for (int i = 0; i < 400; i++) begin
            imem.gnt    = 1'($urandom_range(0, 1));
            lat         = int'($urandom_range(1, 4));
            StallD_i    = ($urandom_range(0, 3) == 0);
            PCSrcE_i    = ($urandom_range(0, 19) == 0);
            PCTargetE_i = 32'h0004_0000 + (32'($urandom_range(0, 255)) << 2);
            tick();
        end
        PCSrcE_i = 1'b0;
        StallD_i = 1'b0;
        imem.gnt = 1'b1;
        for (int i = 0; i < 10; i++) tick();

        // Reset mid-stream with two outstanding and two queued
        do_reset();
        lat      = 2;
        StallD_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("s6_inflight", 32'(q_addr.size()), 32'd2);
        chk("s6_valid_pre", 32'(valid_o), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("s6_valid", 32'(valid_o), 32'd0);
        chk("s6_instr", InstrD_o, NOP);
        chk("s6_pcd", PCD_o, 32'd0);
        chk("s6_pc4", PCPlus4D_o, 32'd0);
        chk("s6_pcf", PCF_o, PC_START);
        do_reset();
        StallD_i = 1'b0;
        wait_valid("s6_first", PC_START);
        for (int i = 0; i < 8; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
